// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: mnemonic codes, opcodes, R-type funct
// codes, loader FSM states and an opcode lookup helper.
package mips_pkg;

  typedef enum logic [3:0] {
    MN_RTYPE = 4'd0,
    MN_LW    = 4'd1,
    MN_SW    = 4'd2,
    MN_BEQ   = 4'd3,
    MN_ADDI  = 4'd4,
    MN_ORI   = 4'd5,
    MN_J     = 4'd6,
    MN_BNE   = 4'd7,
    MN_LH    = 4'd8,
    MN_LB    = 4'd9,
    MN_LBU   = 4'd10,
    MN_ANDI  = 4'd11
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  // Common R-type function codes (funct is passed through from the bundle).
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Loader FSM states.
  typedef logic [0:0] state_t;
  localparam state_t ST_LOAD = 1'b0;
  localparam state_t ST_DONE = 1'b1;

  typedef struct packed {
    logic       legal;
    logic [5:0] op;
  } op_info_t;

  // Mnemonic -> opcode; codes 12..15 come back flagged illegal.
  function automatic op_info_t op_lookup(input logic [3:0] m);
    op_info_t r;
    r.legal = 1'b1;
    r.op    = OP_RTYPE;
    case (m)
      MN_RTYPE: r.op = OP_RTYPE;
      MN_LW:    r.op = OP_LW;
      MN_SW:    r.op = OP_SW;
      MN_BEQ:   r.op = OP_BEQ;
      MN_ADDI:  r.op = OP_ADDI;
      MN_ORI:   r.op = OP_ORI;
      MN_J:     r.op = OP_J;
      MN_BNE:   r.op = OP_BNE;
      MN_LH:    r.op = OP_LH;
      MN_LB:    r.op = OP_LB;
      MN_LBU:   r.op = OP_LBU;
      MN_ANDI:  r.op = OP_ANDI;
      default:  r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: mnemonic + register/immediate fields -> 32-bit
// MIPS word, plus an illegal-mnemonic flag.
module instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  op_info_t w_info;

  // Select the R/J/I layout from the mnemonic; shamt is always zero.
  always_comb begin
    w_info  = op_lookup(mnem);
    illegal = !w_info.legal;
    case (mnem)
      MN_RTYPE: word = {w_info.op, rs, rt, rd, 5'b00000, funct};
      MN_J:     word = {w_info.op, target};
      default:  word = {w_info.op, rs, rt, imm};
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction loader: accepts field bundles, encodes them and streams the
// words into instruction memory through a one-entry output register.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              last,
  input  logic              restart,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  logic                r_wr_valid;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;
  logic [ADDR_W:0]     r_count;
  logic                r_err;
  logic                r_last_pend;

  logic [31:0]         w_word;
  logic                w_illegal;
  logic                w_acc;
  logic                w_wr_done;
  logic [ADDR_W:0]     w_cnt_nxt;
  logic                w_fin;

  instr_pack u_pack (
    .mnem    (mnem),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .funct   (funct),
    .imm     (imm),
    .target  (target),
    .word    (w_word),
    .illegal (w_illegal)
  );

  assign in_ready  = (r_state == ST_LOAD) && (!r_wr_valid || wr_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_wr_done = r_wr_valid && wr_ready;
  assign w_cnt_nxt = r_count + 1'b1;
  // Load ends when the last-tagged word lands, memory fills, or an
  // illegal last-tagged bundle is consumed (nothing can be pending then).
  assign w_fin     = (w_wr_done && (r_last_pend || (w_cnt_nxt == CNT_FULL)))
                   || (w_acc && w_illegal && last);

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign count    = r_count;
  assign done     = (r_state == ST_DONE);
  assign err      = r_err;

  // Loader FSM, output register and address/count bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_LOAD;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= BASE_A;
      r_wr_data   <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_last_pend <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      if (w_wr_done) begin
        r_wr_addr <= r_wr_addr + 1'b1;
        r_count   <= w_cnt_nxt;
      end
      if (w_acc && !w_illegal) begin
        r_wr_valid  <= 1'b1;
        r_wr_data   <= w_word;
        r_last_pend <= last;
      end else if (w_wr_done) begin
        r_wr_valid <= 1'b0;
      end
      if (w_acc && w_illegal)
        r_err <= 1'b1;
      // Anything accepted alongside the finishing write is dropped.
      if (w_fin) begin
        r_state    <= ST_DONE;
        r_wr_valid <= 1'b0;
      end
    end else if (restart) begin
      r_state   <= ST_LOAD;
      r_wr_addr <= BASE_A;
      r_count   <= '0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_instr_encoder;

  localparam int AW   = 6;
  localparam int BS   = 0;
  localparam int NWRD = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    mnem;
  logic [4:0]    rs, rt, rd;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          last;
  logic          restart;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  instr_encoder #(.ADDR_W(AW), .BASE(BS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .target(target), .last(last), .restart(restart), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of words awaiting their memory write.
  typedef struct { logic [31:0] w; bit lst; } ent_t;
  ent_t q[$];
  bit   m_done, m_err, sent_last;
  int   m_count, m_addr;

  function automatic logic [31:0] ref_word(input int m, input int a, input int b,
                                           input int c, input int f, input int i,
                                           input int t);
    int    opc[12] = '{0, 35, 43, 4, 8, 13, 2, 5, 33, 32, 36, 12};
    longint v;
    if (m == 0)      v = longint'(opc[m]) * 2**26 + a * 2**21 + b * 2**16 + c * 2**11 + f;
    else if (m == 6) v = longint'(opc[m]) * 2**26 + t;
    else             v = longint'(opc[m]) * 2**26 + a * 2**21 + b * 2**16 + i;
    return v[31:0];
  endfunction

  task automatic model_clear();
    q.delete();
    m_done = 0; m_err = 0; m_count = 0; m_addr = BS; sent_last = 0;
  endtask

  // One clock: inputs already set at the negedge; check, update model, advance.
  task automatic cyc();
    bit   exp_rdy, acc, wdone, lst;
    ent_t e;
    #1;
    exp_rdy = !m_done && (q.size() == 0 || wr_ready);
    check("in_ready", in_ready, exp_rdy);
    check("wr_valid", wr_valid, q.size() != 0);
    if (q.size() != 0) check("wr_data", wr_data, q[0].w);
    check("wr_addr", wr_addr, m_addr);
    check("count", count, m_count);
    check("done", done, m_done);
    check("err", err, m_err);
    acc   = in_valid && exp_rdy;
    wdone = (q.size() != 0) && wr_ready;
    if (!m_done) begin
      if (wdone) begin
        lst = q[0].lst;
        void'(q.pop_front());
        m_addr = (m_addr + 1) % NWRD;
        m_count++;
        if (lst || m_count == NWRD) m_done = 1;
      end
      if (acc) begin
        if (mnem < 12) begin
          e.w = ref_word(mnem, rs, rt, rd, funct, imm, target);
          e.lst = last;
          q.push_back(e);
        end else begin
          m_err = 1;
          if (last) m_done = 1;
        end
        if (last) sent_last = 1;
      end
      if (m_done) q.delete();
    end else if (restart) begin
      m_done = 0; m_addr = BS; m_count = 0; sent_last = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_wr_valid", wr_valid, 0);
    check("rst_count", count, 0);
    check("rst_wr_addr", wr_addr, BS);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic bundle(input int m, input int a, input int b, input int c,
                        input int f, input int i, input int t, input bit l);
    in_valid = 1'b1; mnem = 4'(m); rs = 5'(a); rt = 5'(b); rd = 5'(c);
    funct = 6'(f); imm = 16'(i); target = 26'(t); last = l;
  endtask

  logic [31:0] hold_d;
  logic [AW-1:0] hold_a;
  int c0;

  initial begin
    reset = 1'b0; in_valid = 0; mnem = 0; rs = 0; rt = 0; rd = 0; funct = 0;
    imm = 0; target = 0; last = 0; restart = 0; wr_ready = 0;
    model_clear();
    @(negedge clk);
    do_reset();
    cyc();
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // ADDI, then RTYPE and J streamed back-to-back.
    bundle(4, 0, 2, 0, 0, 5, 0, 0); wr_ready = 0;
    cyc();
    check("addi_wv", wr_valid, 1);
    check("addi_data", wr_data, 32'h20020005);
    check("addi_addr", wr_addr, 0);
    bundle(0, 4, 5, 6, 6'b100000, 0, 0, 0); wr_ready = 1;
    cyc();
    check("rtype_data", wr_data, 32'h00853020);
    bundle(6, 0, 0, 0, 0, 0, 32'h11, 0);
    cyc();
    check("j_data", wr_data, 32'h08000011);

    // Stall: ORI presented while J waits for wr_ready.
    bundle(5, 1, 2, 0, 0, 16'h00ff, 0, 0); wr_ready = 0;
    hold_d = wr_data; hold_a = wr_addr;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("stall_data", wr_data, hold_d);
      check("stall_addr", wr_addr, hold_a);
    end
    wr_ready = 1;
    cyc();
    in_valid = 0;
    cyc();
    check("stall_count", count, 4);

    // Three bundles, third last, then restart.
    do_reset();
    wr_ready = 1;
    bundle(1, 3, 4, 0, 0, 16'h0010, 0, 0); cyc();
    bundle(2, 3, 4, 0, 0, 16'h0020, 0, 0); cyc();
    bundle(11, 7, 8, 0, 0, 16'h0f0f, 0, 1); cyc();
    in_valid = 0; last = 0;
    cyc(); cyc();
    check("last_count", count, 3);
    check("last_done", done, 1);
    check("last_in_ready", in_ready, 0);
    restart = 1; cyc(); restart = 0;
    check("rs_addr", wr_addr, BS);
    check("rs_count", count, 0);

    // Illegal mnemonic: err, no write, count unchanged.
    c0 = count;
    bundle(13, 1, 1, 1, 1, 1, 1, 0); cyc();
    in_valid = 0; cyc();
    check("ill_err", err, 1);
    check("ill_wv", wr_valid, 0);
    check("ill_count", count, c0);
    bundle(14, 0, 0, 0, 0, 0, 0, 1); cyc();
    in_valid = 0; last = 0;
    check("ill_last_done", done, 1);
    restart = 1; cyc(); restart = 0;
    check("ill_err_kept", err, 1);

    // Reset while a word is stalled.
    bundle(9, 2, 3, 0, 0, 16'h8000, 0, 0); wr_ready = 0; cyc();
    in_valid = 0; cyc();
    check("pre_rst_wv", wr_valid, 1);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      in_valid = !sent_last && ($urandom_range(0, 9) < 7);
      mnem     = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(12, 15))
                                              : 4'($urandom_range(0, 11));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
      last     = ($urandom_range(0, 24) == 0);
      wr_ready = ($urandom_range(0, 9) < 7);
      restart  = m_done ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter BASE, default 0, meaning first word address written after reset or restart.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning an instruction-field bundle is presented.
REQ-006 SHALL have port in_ready  output  1  meaning the bundle is accepted this cycle when in_valid is also 1.
REQ-007 SHALL have port mnem  input  4  meaning the mnemonic code: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 ORI, 6 J, 7 BNE, 8 LH, 9 LB, 10 LBU, 11 ANDI; 12-15 are illegal.
REQ-008 SHALL have ports rs/rt/rd  input  5 each  meaning the register fields.
REQ-009 SHALL have ports funct  input  6  and  imm  input  16  meaning R-type function and I-type immediate.
REQ-010 SHALL have port target  input  26  meaning the J-type target field.
REQ-011 SHALL have port last  input  1  meaning the accepted bundle is the final program word.
REQ-012 SHALL have port restart  input  1  meaning return from DONE to LOAD.
REQ-013 SHALL have ports wr_valid  output  1, wr_ready  input  1, wr_addr  output  ADDR_W, wr_data  output  32  meaning the instruction-memory write port.
REQ-014 SHALL have ports count  output  ADDR_W+1, done  output  1, err  output  1  meaning words written, load complete, and illegal mnemonic seen (sticky).

Function
REQ-015 SHALL encode opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, ORI 001101, J 000010, BNE 000101, LH 100001, LB 100000, LBU 100100, ANDI 001100.
REQ-016 SHALL format RTYPE as op|rs|rt|rd|00000|funct, J as op|target, and all others as op|rs|rt|imm.
REQ-017 SHALL implement FSM states LOAD and DONE; reset enters LOAD.
REQ-018 SHALL drive in_ready = (state==LOAD) && (!wr_valid || wr_ready).
REQ-019 SHALL register the encoded word into a one-entry output register on acceptance, with wr_valid rising the next cycle (latency 1).
REQ-020 SHALL hold wr_valid, wr_addr and wr_data stable until wr_ready; on the same cycle a write completes, a new bundle may be accepted (full throughput).
REQ-021 SHALL increment wr_addr and count on each completed write (wr_valid && wr_ready); wr_addr wraps modulo 2^ADDR_W.
REQ-022 SHALL transition LOAD->DONE when the write of a bundle tagged last completes, or when count reaches 2^ADDR_W.
REQ-023 SHALL hold done=1 and in_ready=0 in DONE; restart in DONE returns to LOAD with wr_addr=BASE and count=0, with err unchanged.
REQ-024 SHALL ignore restart while in LOAD.
REQ-025 SHALL consume an accepted illegal mnemonic without writing it, and set err; when that bundle is tagged last, SHALL enter DONE on the next cycle, provided no write is pending.

Reset
REQ-026 SHALL on reset assert asynchronously: state LOAD, wr_valid 0, wr_addr BASE, wr_data 0, count 0, done 0, err 0.
REQ-027 SHALL discard any pending unwritten word when reset asserts mid-operation.

Structure
REQ-028 SHALL place the mnemonic enum, the opcode constants, the FSM state typedef and the R-type funct constants in the shared package mips_pkg.
REQ-029 SHALL isolate the combinational field packing in one sub-module, instr_pack (mnem+fields -> 32-bit word + illegal flag).

Verification
REQ-030 SHALL verify: ADDI rs=0 rt=2 imm=5 -> wr_data 0x20020005 at wr_addr 0, wr_valid one cycle after accept.
REQ-031 SHALL verify: RTYPE rs=4 rt=5 rd=6 funct=100000 -> wr_data 0x00853020; J target=0x11 -> wr_data 0x08000011.
REQ-032 SHALL verify: wr_ready held 0 for 3 cycles -> wr_data/wr_addr stable, in_ready 0, with no bundle lost or duplicated.
REQ-033 SHALL verify: 3 bundles, the third tagged last -> count 3, done 1, in_ready 0; restart -> wr_addr 0 and count 0.
REQ-034 SHALL verify: mnem=13 -> err 1, no write, count unchanged; reset low mid-stall -> wr_valid 0 immediately.
